// File: rtl/l2_cache_control_if.sv
// Arbiter and physical-memory handshake bundle for the L2 cache controller.
// The slave side is the controller; the master side is its environment
// (request arbiter plus physical memory).
interface l2_cache_control_if;
    logic mem_read;
    logic mem_write;
    logic mem_resp;
    logic pmem_read;
    logic pmem_write;
    logic pmem_resp;

    modport master (
        output mem_read,
        output mem_write,
        output pmem_resp,
        input  mem_resp,
        input  pmem_read,
        input  pmem_write
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  pmem_resp,
        output mem_resp,
        output pmem_read,
        output pmem_write
    );
endinterface

// File: rtl/l2_cache_control.sv
// L2 cache controller FSM: hit check, dirty-victim writeback, line fill,
// plus saturating hit/miss performance counters that ignore post-fill hits.
module l2_cache_control #(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    l2_cache_control_if.slave  bus,
    input  logic               in_cache,
    input  logic               dirty_overwrite,
    output logic               cache_write,
    output logic               cache_read,
    output logic               from_processor,
    output logic               read,
    output logic               write,
    output logic               lru_update,
    output logic               miss_cache_read,
    output logic [CNT_W-1:0]   hit_count,
    output logic [CNT_W-1:0]   miss_count
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITEBACK,
        FETCH
    } state_t;

    state_t state;
    state_t next_state;
    logic   refill;
    logic   req;
    logic   is_write;
    logic   check_hit;
    logic   check_miss;

    // A simultaneous read and write strobe is serviced as a write.
    assign req        = bus.mem_read | bus.mem_write;
    assign is_write   = bus.mem_write;
    assign check_hit  = (state == CHECK) && req && in_cache;
    assign check_miss = (state == CHECK) && req && !in_cache;

    // State register; reset abandons any pmem transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a dropped request still lets the fill finish, then CHECK falls back to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (!req || in_cache) begin
                    next_state = IDLE;
                end else if (dirty_overwrite) begin
                    next_state = WRITEBACK;
                end else begin
                    next_state = FETCH;
                end
            end
            WRITEBACK: begin
                if (bus.pmem_resp) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                if (bus.pmem_resp) begin
                    next_state = CHECK;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath and memory controls; everything idles low unless the current state drives it.
    always_comb begin
        cache_write     = 1'b0;
        cache_read      = 1'b0;
        from_processor  = 1'b0;
        read            = 1'b0;
        write           = 1'b0;
        lru_update      = 1'b0;
        miss_cache_read = 1'b0;
        bus.mem_resp    = 1'b0;
        bus.pmem_read   = 1'b0;
        bus.pmem_write  = 1'b0;
        case (state)
            CHECK: begin
                if (req && in_cache) begin
                    lru_update   = 1'b1;
                    bus.mem_resp = 1'b1;
                    if (is_write) begin
                        write          = 1'b1;
                        cache_write    = 1'b1;
                        from_processor = 1'b1;
                    end else begin
                        read       = 1'b1;
                        cache_read = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                miss_cache_read = 1'b1;
                bus.pmem_write  = 1'b1;
            end
            FETCH: begin
                bus.pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    cache_write = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Refill flag marks the re-check after a fill so its hit is not counted; counters saturate.
    always_ff @(posedge clk) begin
        if (!rst) begin
            refill     <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (next_state == IDLE) begin
                refill <= 1'b0;
            end else if (check_miss) begin
                refill <= 1'b1;
            end
            if (check_hit && !refill && (hit_count != '1)) begin
                hit_count <= hit_count + CNT_W'(1);
            end
            if (check_miss && !refill && (miss_count != '1)) begin
                miss_count <= miss_count + CNT_W'(1);
            end
        end
    end

endmodule
